// File: rtl/async_fifo_wptr_full_level.sv
// ----------------------------------------------------------------------------
// async_fifo_wptr_full_level
//
// Write-side pointer and status block of a dual-clock FIFO. It owns the
// binary write counter, publishes the Gray write pointer for the read
// domain, and derives full / almost-full / fill level / overflow from the
// Gray read pointer that has already been synchronized into wclk.
//
// Write handshake: winc is the producer's request and wen is the grant.
// A word is written (and the pointer advances) exactly on cycles where
// winc=1 and wfull=0; wen reflects that combinationally. A request made
// while full is dropped and flags wovf on the next edge.
//
// Ports
//   wclk      in   1            write-domain clock
//   wrst_n    in   1            asynchronous active-low reset
//   winc      in   1            write request
//   wq2_rptr  in   ADDRSIZE+1   Gray read pointer, synchronized into wclk
//   ovf_clr   in   1            synchronous clear of wovf
//   wen       out  1            memory write enable (combinational)
//   waddr     out  ADDRSIZE     binary memory write address
//   wptr      out  ADDRSIZE+1   registered Gray write pointer
//   wfull     out  1            registered full flag
//   wafull    out  1            registered almost-full flag
//   wlevel    out  ADDRSIZE+1   registered fill level, 0..2**ADDRSIZE
//   wovf      out  1            sticky overflow flag
// ----------------------------------------------------------------------------
module async_fifo_wptr_full_level #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 14
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic                ovf_clr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                wafull,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                wovf
);

    localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AFULL_THRESH);

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] level_next;
    logic              full_val;

    assign wen       = winc & ~wfull;
    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wen};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;
    assign waddr     = wbin[ADDRSIZE-1:0];

    // Full when the next write pointer is exactly one lap ahead of the read
    // pointer: in Gray code that is the two MSBs inverted, the rest equal.
    assign full_val = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                     wq2_rptr[ADDRSIZE-2:0]});

    // Gray to binary: each binary bit is the XOR of all Gray bits at and
    // above it.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin_s[i] = ^(wq2_rptr >> i);
        end
    end

    // A stale read pointer only lags, so this difference can only overstate
    // occupancy, never understate it.
    assign level_next = wbinnext - rbin_s;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin   <= '0;
            wptr   <= '0;
            wfull  <= 1'b0;
            wafull <= 1'b0;
            wlevel <= '0;
        end else begin
            wbin   <= wbinnext;
            wptr   <= wgraynext;
            wfull  <= full_val;
            wafull <= (level_next >= THRESH);
            wlevel <= level_next;
        end
    end

    // Sticky overflow: a set in the same cycle as a clear takes priority.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wovf <= 1'b0;
        end else if (winc && wfull) begin
            wovf <= 1'b1;
        end else if (ovf_clr) begin
            wovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_async_fifo_wptr_full_level.sv
module tb_async_fifo_wptr_full_level;

    localparam int A     = 4;
    localparam int DEPTH = 1 << A;
    localparam int AF    = 14;

    logic         wclk;
    logic         wrst_n;
    logic         winc;
    logic [A:0]   wq2_rptr;
    logic         ovf_clr;
    logic         wen;
    logic [A-1:0] waddr;
    logic [A:0]   wptr;
    logic         wfull;
    logic         wafull;
    logic [A:0]   wlevel;
    logic         wovf;

    async_fifo_wptr_full_level #(.ADDRSIZE(A), .AFULL_THRESH(AF)) dut (
        .wclk    (wclk),
        .wrst_n  (wrst_n),
        .winc    (winc),
        .wq2_rptr(wq2_rptr),
        .ovf_clr (ovf_clr),
        .wen     (wen),
        .waddr   (waddr),
        .wptr    (wptr),
        .wfull   (wfull),
        .wafull  (wafull),
        .wlevel  (wlevel),
        .wovf    (wovf)
    );

    // clock / reset
    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    int errors = 0;
    int checks = 0;

    // reference model: total accepted writes and total reads as plain integers
    int   m_w;
    int   m_r;
    logic m_full;
    logic m_ovf;

    // scoreboard entries: {wfull, wafull, wlevel, wptr, waddr, wovf}
    logic [16:0] exp_q[$];

    function automatic logic [A:0] to_gray(input int n);
        logic [A:0] b;
        b = (A+1)'(n % (2 * DEPTH));
        return (b >> 1) ^ b;
    endfunction

    task automatic model_reset();
        m_w = 0;
        m_r = 0;
        m_full = 1'b0;
        m_ovf = 1'b0;
        exp_q.delete();
    endtask

    // Called just after a rising edge: drive one cycle, check wen mid-cycle,
    // check registered outputs just after the next rising edge.
    task automatic do_cycle(input logic w, input logic c, input int adv);
        logic        exp_wen;
        int          occ;
        int          nw;
        logic [16:0] e;
        logic [16:0] got;
        logic        e_full, e_afull, e_ovf;
        m_r      = m_r + adv;
        wq2_rptr = to_gray(m_r);
        winc     = w;
        ovf_clr  = c;
        exp_wen  = w && !m_full;
        nw       = m_w + (exp_wen ? 1 : 0);
        occ      = nw - m_r;
        e_full   = (occ == DEPTH);
        e_afull  = (occ >= AF);
        e_ovf    = (w && m_full) ? 1'b1 : (c ? 1'b0 : m_ovf);
        exp_q.push_back({e_full, e_afull, (A+1)'(occ), to_gray(nw),
                         A'(nw % DEPTH), e_ovf});
        @(negedge wclk);
        checks++;
        if (wen !== exp_wen) begin
            errors++;
            $display("FAIL wen: got %b expected %b (t=%0t)", wen, exp_wen, $time);
        end
        @(posedge wclk);
        #1;
        e   = exp_q.pop_front();
        got = {wfull, wafull, wlevel, wptr, waddr, wovf};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL scoreboard {full,afull,level,wptr,waddr,ovf}: got %h expected %h (t=%0t)",
                     got, e, $time);
        end
        m_w    = nw;
        m_full = e_full;
        m_ovf  = e_ovf;
        winc    = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({wfull, wafull, wlevel, wptr, waddr, wovf} !== 17'h0) begin
            errors++;
            $display("FAIL %s: got full=%b afull=%b level=%0d wptr=%b waddr=%0d ovf=%b expected all 0",
                     tag, wfull, wafull, wlevel, wptr, waddr, wovf);
        end
    endtask

    task automatic test_reset();
        winc = 1'b0;
        ovf_clr = 1'b0;
        wq2_rptr = '0;
        wrst_n = 1'b1;
        #1 wrst_n = 1'b0;
        #2;
        check_all_zero("reset_initial");
        #9 wrst_n = 1'b1;        // t=12, away from edges
        model_reset();
        @(posedge wclk);
        #1;
        // burst of writes, then reset asserted between edges
        for (int i = 0; i < 5; i++) do_cycle(1'b1, 1'b0, 0);
        winc = 1'b1;
        #1 wrst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_burst");
        winc = 1'b0;
        #1 wrst_n = 1'b1;
        model_reset();
        @(posedge wclk);
        #1;
        check_all_zero("reset_after_release_idle");
    endtask

    task automatic test_almost_full();
        for (int i = 0; i < 13; i++) do_cycle(1'b1, 1'b0, 0);
        checks++;
        if (wafull !== 1'b0 || wlevel !== 5'd13) begin
            errors++;
            $display("FAIL afull_13: got afull=%b level=%0d expected afull=0 level=13", wafull, wlevel);
        end
        do_cycle(1'b1, 1'b0, 0);
        checks++;
        if (wafull !== 1'b1 || wlevel !== 5'd14) begin
            errors++;
            $display("FAIL afull_14: got afull=%b level=%0d expected afull=1 level=14", wafull, wlevel);
        end
    endtask

    task automatic test_fill();
        do_cycle(1'b1, 1'b0, 0);
        checks++;
        if (wfull !== 1'b0 || wlevel !== 5'd15) begin
            errors++;
            $display("FAIL fill_15: got full=%b level=%0d expected full=0 level=15", wfull, wlevel);
        end
        do_cycle(1'b1, 1'b0, 0);
        checks++;
        if (wfull !== 1'b1 || wlevel !== 5'd16 || wptr !== 5'b11000 || waddr !== 4'd0) begin
            errors++;
            $display("FAIL fill_16: got full=%b level=%0d wptr=%b waddr=%0d expected 1 16 11000 0",
                     wfull, wlevel, wptr, waddr);
        end
    endtask

    task automatic test_overflow();
        do_cycle(1'b1, 1'b0, 0);
        checks++;
        if (wptr !== 5'b11000 || wovf !== 1'b1 || wfull !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got wptr=%b ovf=%b full=%b expected 11000 1 1", wptr, wovf, wfull);
        end
        do_cycle(1'b0, 1'b1, 0);
        checks++;
        if (wovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: got ovf=%b expected 0", wovf);
        end
        do_cycle(1'b1, 1'b1, 0);
        checks++;
        if (wovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins: got ovf=%b expected 1", wovf);
        end
        do_cycle(1'b0, 1'b1, 0);
    endtask

    task automatic test_drain();
        logic [A:0] lv_exp;
        for (int i = 1; i <= 3; i++) begin
            do_cycle(1'b0, 1'b0, 1);
            lv_exp = (A+1)'(DEPTH - i);
            checks++;
            if (wfull !== 1'b0 || wlevel !== lv_exp) begin
                errors++;
                $display("FAIL drain_%0d: got full=%b level=%0d expected full=0 level=%0d",
                         i, wfull, wlevel, lv_exp);
            end
        end
    endtask

    task automatic test_wrap();
        int         writes;
        int         cyc;
        logic [A:0] prev;
        logic       saw_wrap;
        logic       w;
        int         adv;
        writes   = 0;
        cyc      = 0;
        saw_wrap = 1'b0;
        prev     = wptr;
        while (writes < 40 && cyc < 300) begin
            w   = ($urandom_range(0, 3) != 0);
            adv = ((m_w - m_r) > 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
            if (w && !m_full) writes++;
            do_cycle(w, 1'b0, adv);
            checks++;
            if ($countones(wptr ^ prev) > 1) begin
                errors++;
                $display("FAIL wptr_one_bit: got %b after %b expected at most one bit change", wptr, prev);
            end
            if (prev == 5'b10000 && wptr == 5'b00000) saw_wrap = 1'b1;
            prev = wptr;
            cyc++;
        end
        checks++;
        if (writes !== 40) begin
            errors++;
            $display("FAIL wrap_budget: got %0d writes expected 40", writes);
        end
        checks++;
        if (saw_wrap !== 1'b1) begin
            errors++;
            $display("FAIL wrap_seen: got %b expected 1 (wptr 10000 -> 00000)", saw_wrap);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_almost_full();
        test_fill();
        test_overflow();
        test_drain();
        test_wrap();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
